// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter and its environment (reader, writer, RAM).
// master: the pixel-fetch/writer/RAM side; slave: the arbiter.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WFIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(WFIFO_DEPTH) + 1;

    logic              iRD_REQ;
    logic [ADDR_W-1:0] iRD_ADDR;
    logic              oRD_VALID;
    logic [DATA_W-1:0] oRD_DATA;
    logic              iWR_VALID;
    logic [ADDR_W-1:0] iWR_ADDR;
    logic [DATA_W-1:0] iWR_DATA;
    logic              oWR_READY;
    logic              oWR_EMPTY;
    logic [LVL_W-1:0]  oWR_LEVEL;
    logic [15:0]       oSTALL_CNT;
    logic              iVBLANK;
    logic [ADDR_W-1:0] oMEM_ADDR;
    logic              oMEM_WE;
    logic [DATA_W-1:0] oMEM_WDATA;
    logic [DATA_W-1:0] iMEM_RDATA;

    modport master (
        output iRD_REQ, iRD_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA, iVBLANK, iMEM_RDATA,
        input  oRD_VALID, oRD_DATA, oWR_READY, oWR_EMPTY, oWR_LEVEL, oSTALL_CNT,
               oMEM_ADDR, oMEM_WE, oMEM_WDATA
    );

    modport slave (
        input  iRD_REQ, iRD_ADDR, iWR_VALID, iWR_ADDR, iWR_DATA, iVBLANK, iMEM_RDATA,
        output oRD_VALID, oRD_DATA, oWR_READY, oWR_EMPTY, oWR_LEVEL, oSTALL_CNT,
               oMEM_ADDR, oMEM_WE, oMEM_WDATA
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: reads win with fixed 2-cycle latency, writes queue in a FIFO
// and commit in reader-idle cycles. Macro FB_ARB_VBLANK_ONLY_EN limits commits to vertical blanking.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic            iCLK,
    input  logic            iRST_n,
    vga_fb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} grant_e;

    wr_entry_t         fifo_q [WFIFO_DEPTH];
    wr_entry_t         fifo_d [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [1:0]        rd_pipe_q, rd_pipe_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_ready_q, wr_ready_d;
    logic              wr_empty_q, wr_empty_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    grant_e            grant;
    logic              gate_open, push, pop, fifo_empty;
    wr_entry_t         head;

`ifdef FB_ARB_VBLANK_ONLY_EN
    assign gate_open = bus.iVBLANK;
`else
    logic vblank_unused;
    assign vblank_unused = bus.iVBLANK;
    assign gate_open     = 1'b1;
`endif

    // Grant decision, FIFO bookkeeping and next values of every registered output
    always_comb begin
        grant       = GNT_IDLE;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        stall_cnt_d = stall_cnt_q;

        fifo_empty = (level_q == '0);
        head       = fifo_q[rd_ptr_q];
        push       = bus.iWR_VALID && wr_ready_q;

        if (bus.iRD_REQ) begin
            grant = GNT_READ;
        end else if (!fifo_empty && gate_open) begin
            grant = GNT_WRITE;
        end
        pop = (grant == GNT_WRITE);

        if (grant == GNT_READ) begin
            mem_addr_d = bus.iRD_ADDR;
        end else if (pop) begin
            mem_addr_d  = head.addr;
            mem_wdata_d = head.data;
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end
        mem_we_d = pop;

        if (push) begin
            fifo_d[wr_ptr_q] = '{addr: bus.iWR_ADDR, data: bus.iWR_DATA};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        wr_ready_d = (level_d < LVL_W'(WFIFO_DEPTH));
        wr_empty_d = (level_d == '0) && !pop;

        if (!fifo_empty && !pop && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Issue flag rides two stages so capture lines up with the RAM's registered read
        rd_pipe_d  = {rd_pipe_q[0], bus.iRD_REQ};
        rd_valid_d = rd_pipe_q[1];
        rd_data_d  = rd_pipe_q[1] ? bus.iMEM_RDATA : rd_data_q;
    end

    always_ff @(posedge iCLK) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_pipe_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ready_q  <= 1'b1;
            wr_empty_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ready_q  <= wr_ready_d;
            wr_empty_q  <= wr_empty_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.oRD_VALID  = rd_valid_q;
    assign bus.oRD_DATA   = rd_data_q;
    assign bus.oWR_READY  = wr_ready_q;
    assign bus.oWR_EMPTY  = wr_empty_q;
    assign bus.oWR_LEVEL  = level_q;
    assign bus.oSTALL_CNT = stall_cnt_q;
    assign bus.oMEM_ADDR  = mem_addr_q;
    assign bus.oMEM_WE    = mem_we_q;
    assign bus.oMEM_WDATA = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: vector table, read-latency scoreboard and
// hand-written corner sequences; RAM modelled as registered-read memory holding addr[7:0].
module tb_vga_fb_arbiter;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic iCLK   = 1'b0;
    logic iRST_n = 1'b0;
    always #5 iCLK = ~iCLK;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(DEPTH)) bus ();

    vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WFIFO_DEPTH(DEPTH)) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    // RAM with one-cycle registered read
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge iCLK) begin
        if (bus.oMEM_WE) ram[bus.oMEM_ADDR] <= bus.oMEM_WDATA;
        bus.iMEM_RDATA <= ram[bus.oMEM_ADDR];
    end

    typedef struct {
        int          due;
        logic [7:0]  data;
    } rd_exp_t;
    rd_exp_t sbq[$];

    typedef struct {
        int rd, ra, wv, wa, wd;
        int we, addr, wdata, lvl, rdy, empty, stall;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #2;
    endtask

    task automatic drive(input int rd, input int ra, input int wv, input int wa, input int wd);
        rd_exp_t e;
        bus.iRD_REQ   = (rd != 0);
        bus.iRD_ADDR  = ADDR_W'(ra);
        bus.iWR_VALID = (wv != 0);
        bus.iWR_ADDR  = ADDR_W'(wa);
        bus.iWR_DATA  = DATA_W'(wd);
        if (rd != 0) begin
            e.due  = cyc + 3;
            e.data = 8'(ra);
            sbq.push_back(e);
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        bus.iVBLANK = 1'b1;
        iRST_n = 1'b0;
        sbq.delete();
        tick();
        iRST_n = 1'b1;
    endtask

    // Read scoreboard: each issued read must surface exactly at its due cycle
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge iCLK);
            #1;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("rd_valid", 32'(bus.oRD_VALID), 32'd1);
                chk("rd_data", 32'(bus.oRD_DATA), 32'(e.data));
            end else begin
                chk("rd_unexpected_valid", 32'(bus.oRD_VALID), 32'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'(i);

        vt[0] = '{1, 5, 1, 50, 'h11,  0,  5, 'h00, 1, 1, 0, 0};
        vt[1] = '{0, 0, 0,  0,    0,  1, 50, 'h11, 0, 1, 0, 0};
        vt[2] = '{0, 0, 1, 51, 'h22,  0, 50, 'h11, 1, 1, 0, 0};
        vt[3] = '{0, 0, 1, 52, 'h33,  1, 51, 'h22, 1, 1, 0, 0};
        vt[4] = '{1, 7, 0,  0,    0,  0,  7, 'h22, 1, 1, 0, 1};
        vt[5] = '{0, 0, 0,  0,    0,  1, 52, 'h33, 0, 1, 0, 1};
        vt[6] = '{0, 0, 0,  0,    0,  0, 52, 'h33, 0, 1, 1, 1};

        // Reset then idle
        do_reset();
        chk("rst_rd_valid", 32'(bus.oRD_VALID), 32'd0);
        chk("rst_rd_data", 32'(bus.oRD_DATA), 32'd0);
        chk("rst_mem_addr", 32'(bus.oMEM_ADDR), 32'd0);
        chk("rst_mem_we", 32'(bus.oMEM_WE), 32'd0);
        chk("rst_mem_wdata", 32'(bus.oMEM_WDATA), 32'd0);
        chk("rst_level", 32'(bus.oWR_LEVEL), 32'd0);
        chk("rst_stall", 32'(bus.oSTALL_CNT), 32'd0);
        chk("rst_ready", 32'(bus.oWR_READY), 32'd1);
        chk("rst_empty", 32'(bus.oWR_EMPTY), 32'd1);

        // Vector table: mixed grants, push-then-pop timing, read priority
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].rd, vt[i].ra, vt[i].wv, vt[i].wa, vt[i].wd);
            tick();
            chk($sformatf("vec%0d_we", i), 32'(bus.oMEM_WE), 32'(vt[i].we));
            chk($sformatf("vec%0d_addr", i), 32'(bus.oMEM_ADDR), 32'(vt[i].addr));
            chk($sformatf("vec%0d_wdata", i), 32'(bus.oMEM_WDATA), 32'(vt[i].wdata));
            chk($sformatf("vec%0d_level", i), 32'(bus.oWR_LEVEL), 32'(vt[i].lvl));
            chk($sformatf("vec%0d_ready", i), 32'(bus.oWR_READY), 32'(vt[i].rdy));
            chk($sformatf("vec%0d_empty", i), 32'(bus.oWR_EMPTY), 32'(vt[i].empty));
            chk($sformatf("vec%0d_stall", i), 32'(bus.oSTALL_CNT), 32'(vt[i].stall));
        end

        // Continuous back-to-back reads
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1, i, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();

        // Writes queued behind 10 reads, then drained in order
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 200 + i, (i < 4) ? 1 : 0, 100 + i, 'hA0 + i);
            tick();
            chk("wdr_we_blocked", 32'(bus.oMEM_WE), 32'd0);
            if (i == 2) chk("wdr_ready_lvl3", 32'(bus.oWR_READY), 32'd1);
            if (i == 3) begin
                chk("wdr_ready_full", 32'(bus.oWR_READY), 32'd0);
                chk("wdr_level_full", 32'(bus.oWR_LEVEL), 32'd4);
            end
        end
        chk("wdr_stall", 32'(bus.oSTALL_CNT), 32'd9);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wdr_we", 32'(bus.oMEM_WE), 32'd1);
            chk("wdr_addr", 32'(bus.oMEM_ADDR), 32'(100 + i));
            chk("wdr_wdata", 32'(bus.oMEM_WDATA), 32'('hA0 + i));
            chk("wdr_level", 32'(bus.oWR_LEVEL), 32'(3 - i));
            chk("wdr_ready", 32'(bus.oWR_READY), 32'd1);
        end
        chk("wdr_empty_inflight", 32'(bus.oWR_EMPTY), 32'd0);
        chk("wdr_stall_final", 32'(bus.oSTALL_CNT), 32'd9);
        tick();
        chk("wdr_empty_done", 32'(bus.oWR_EMPTY), 32'd1);
        chk("wdr_we_done", 32'(bus.oMEM_WE), 32'd0);

        // Push and pop in the same cycle at level 2
        do_reset();
        drive(1, 210, 1, 300, 'h30);
        tick();
        drive(1, 211, 1, 301, 'h31);
        tick();
        chk("pp_level_pre", 32'(bus.oWR_LEVEL), 32'd2);
        drive(0, 0, 1, 302, 'h32);
        tick();
        chk("pp_level", 32'(bus.oWR_LEVEL), 32'd2);
        chk("pp_we", 32'(bus.oMEM_WE), 32'd1);
        chk("pp_addr", 32'(bus.oMEM_ADDR), 32'd300);
        chk("pp_wdata", 32'(bus.oMEM_WDATA), 32'h30);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("pp_drain_addr", 32'(bus.oMEM_ADDR), 32'(300 + i));
            chk("pp_drain_wdata", 32'(bus.oMEM_WDATA), 32'('h30 + i));
        end
        chk("pp_stall", 32'(bus.oSTALL_CNT), 32'd1);

        // Reset mid-operation with queued writes and reads in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 220 + i, 1, 400 + i, 'h40 + i);
            tick();
        end
        chk("mr_level_pre", 32'(bus.oWR_LEVEL), 32'd3);
        drive(0, 0, 0, 0, 0);
        iRST_n = 1'b0;
        sbq.delete();
        tick();
        iRST_n = 1'b1;
        chk("mr_rd_valid", 32'(bus.oRD_VALID), 32'd0);
        chk("mr_level", 32'(bus.oWR_LEVEL), 32'd0);
        chk("mr_ready", 32'(bus.oWR_READY), 32'd1);
        chk("mr_empty", 32'(bus.oWR_EMPTY), 32'd1);
        chk("mr_mem_addr", 32'(bus.oMEM_ADDR), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("mr_we", 32'(bus.oMEM_WE), 32'd0);
            tick();
        end
        chk("mr_level_after", 32'(bus.oWR_LEVEL), 32'd0);

`ifdef FB_ARB_VBLANK_ONLY_EN
        // Commits held until vertical blanking
        do_reset();
        bus.iVBLANK = 1'b0;
        drive(0, 0, 1, 500, 'h50);
        tick();
        drive(0, 0, 1, 501, 'h51);
        tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("vb_we_held", 32'(bus.oMEM_WE), 32'd0);
        end
        chk("vb_stall", 32'(bus.oSTALL_CNT), 32'd4);
        chk("vb_level", 32'(bus.oWR_LEVEL), 32'd2);
        bus.iVBLANK = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("vb_we", 32'(bus.oMEM_WE), 32'd1);
            chk("vb_addr", 32'(bus.oMEM_ADDR), 32'(500 + i));
            chk("vb_wdata", 32'(bus.oMEM_WDATA), 32'('h50 + i));
        end
        tick();
        chk("vb_empty", 32'(bus.oWR_EMPTY), 32'd1);
`else
        // iVBLANK ignored: commit proceeds with it low
        do_reset();
        bus.iVBLANK = 1'b0;
        drive(0, 0, 1, 500, 'h50);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        chk("nvb_we", 32'(bus.oMEM_WE), 32'd1);
        chk("nvb_addr", 32'(bus.oMEM_ADDR), 32'd500);
        chk("nvb_stall", 32'(bus.oSTALL_CNT), 32'd0);
`endif

        drive(0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("rd_drain", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbiter sharing one single-port synchronous frame-buffer RAM (on-chip M4K) between the VGA scan-out reader and a pixel writer (drawing engine / host). It sits between `vga_controller`'s pixel-fetch path and the RAM.
- The reader has absolute priority and a fixed 2-cycle latency, so scan-out never glitches.
- Writes are buffered in a small FIFO and committed only in cycles the reader leaves the RAM idle.

## Interface
Parameters:
- ADDR_W, 17, frame-buffer address width (320x240 = 76800 words).
- DATA_W, 8, pixel word width (palette index).
- WFIFO_DEPTH, 4, write FIFO entries; power of two, ≥ 2.

Ports:
- iCLK  in  1  pixel-domain clock, same as the VGA controller clock.
- iRST_n  in  1  reset; synchronous, active-low.
- iRD_REQ  in  1  reader fetch request this cycle.
- iRD_ADDR  in  ADDR_W  reader address.
- oRD_VALID  out  1  oRD_DATA holds the result of the request issued 2 cycles earlier.
- oRD_DATA  out  DATA_W  read data.
- iWR_VALID  in  1  writer offers a word.
- iWR_ADDR  in  ADDR_W  write address.
- iWR_DATA  in  DATA_W  write data.
- oWR_READY  out  1  FIFO can accept a word.
- oWR_EMPTY  out  1  no write pending, FIFO empty and none in flight.
- oWR_LEVEL  out  $clog2(WFIFO_DEPTH)+1  FIFO occupancy.
- oSTALL_CNT  out  16  saturating count of write-blocked cycles.
- iVBLANK  in  1  vertical blanking flag; used only when the macro is defined.
- oMEM_ADDR  out  ADDR_W  RAM address, registered.
- oMEM_WE  out  1  RAM write enable, registered.
- oMEM_WDATA  out  DATA_W  RAM write data, registered.
- iMEM_RDATA  in  DATA_W  RAM read data, valid one cycle after oMEM_ADDR.

## Operation
- Each cycle the grant is one of READ, WRITE or IDLE; registered into the oMEM_* outputs at the clock edge.
  - READ when iRD_REQ=1: oMEM_ADDR←iRD_ADDR, oMEM_WE←0.
  - WRITE when iRD_REQ=0, FIFO non-empty, and the commit gate is open: pop the head entry; oMEM_ADDR←head addr, oMEM_WDATA←head data, oMEM_WE←1.
  - IDLE otherwise: oMEM_WE←0; oMEM_ADDR holds its value.
- Read pipeline: a 2-stage valid shift register tracks issued reads; oRD_DATA←iMEM_RDATA on the second stage.
- The reader is never stalled. A read and a write of the same address in the same cycle resolve as read wins; the write is deferred.
- FIFO accept rules:
  - Push when iWR_VALID && oWR_READY; oWR_READY = (level < WFIFO_DEPTH).
  - Push and pop in the same cycle are both legal; the level is unchanged.
  - When full, oWR_READY=0 even if a pop occurs that cycle; ready rises the next cycle.
  - A word pushed in cycle N is poppable at the earliest in cycle N+1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- oWR_EMPTY = level==0 && no WRITE registered in oMEM_WE.
- oSTALL_CNT increments each cycle with FIFO non-empty and grant ≠ WRITE; it saturates at 16'hFFFF and never wraps.
- Reset (iRST_n=0 at an edge) takes effect mid-operation. Every output is forced to its reset value:
  - pending FIFO entries are discarded;
  - in-flight reads are cancelled, oRD_VALID=0 on the next cycle;
  - oMEM_WE=0.

## Timing
- Reset values:
  - 0: oRD_VALID, oRD_DATA, oMEM_ADDR, oMEM_WE, oMEM_WDATA, oWR_LEVEL, oSTALL_CNT.
  - 1: oWR_READY, oWR_EMPTY.
- Read latency is exactly 2 edges. A request sampled at edge k gives oMEM_ADDR valid after k, and oRD_VALID/oRD_DATA valid after k+2, independent of writer traffic.
- Write commit: the earliest RAM write is the edge after the push edge. Worst case is bounded by the reader-idle gap (horizontal/vertical blanking).
- Full throughput: one read or one write per cycle; back-to-back reads are sustained indefinitely.

## Configuration
- FB_ARB_VBLANK_ONLY_EN:
  - Defined: the commit gate opens only while iVBLANK=1, giving tear-free updates. Writes stay queued during active video, even in horizontal blanking, and oSTALL_CNT counts those blocked cycles.
  - Undefined: the gate is always open and iVBLANK is ignored.

## Test plan
- Reset then idle: after iRST_n low for 1 edge, all outputs hold their reset values; oWR_READY=1, oWR_EMPTY=1, oMEM_WE=0.
- Continuous reads: iRD_REQ=1 with addresses 0,1,2,… and RAM model returning data=addr[7:0]. oRD_VALID rises 2 cycles after the first request; oRD_DATA follows 0,1,2,… with no gaps.
- Write during reads: iRD_REQ=1 for 10 cycles, then 0. Push 4 words (addr 100..103, data A0..A3) during the reads.
  - oWR_READY=0 after the 4th push.
  - oMEM_WE stays 0 until iRD_REQ falls; then 4 consecutive WE cycles write 100..103.
  - oSTALL_CNT equals the number of blocked cycles.
- Push and pop in the same cycle with level 2 and iRD_REQ=0: level stays 2 and the RAM receives the oldest entry (FIFO order).
- Reset mid-operation: with 3 queued writes and 2 reads in flight, pulse iRST_n=0. No further oMEM_WE occurs, oRD_VALID=0, oWR_LEVEL=0.
- Macro defined: iRD_REQ=0, iVBLANK=0, push 2 words → no WE and oSTALL_CNT increments. Raise iVBLANK → both committed on the next 2 edges, oWR_EMPTY=1.
